// File: rtl/psum_requant_writer.sv
// psum_requant_writer
//
// Requantises the final-result write stream of the PE system. Each beat
// carries LANES signed ACC_WIDTH-bit accumulators. Every lane goes through
// three steps: add a global bias, apply a round-half-up arithmetic right
// shift, then saturate to a signed OUT_WIDTH value. The packed word is then
// queued together with its address in a small FIFO, which drains over a
// valid/ready interface.
//
// The upstream stream cannot be stalled. The three pipeline stages always
// advance. A word that reaches a full FIFO with no pop in the same cycle is
// dropped, and ovf_sticky is set.
//
// Optional build macro: PSUM_REQUANT_RELU_EN
//   defined   : the final stage clamps to [0, 2^(OUT_WIDTH-1)-1] (fused ReLU)
//   undefined : the final stage saturates to the signed OUT_WIDTH range
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   psum_wen       result beat valid (one beat per asserted cycle)
//   psum_waddr     result address, carried unchanged to out_addr
//   psum_wdata     LANES x ACC_WIDTH signed lanes, lane i at [32i+31:32i]
//   cfg_bias       signed bias added to every lane (ACC_WIDTH >= 32 assumed)
//   cfg_shift      rounding right-shift amount, 0..31
//   clr_ovf        pulse that clears ovf_sticky (a same-cycle drop wins)
//   out_valid      FIFO head is valid
//   out_ready      consumer accepts the head when out_valid is also high
//   out_addr       address of the head word
//   out_data       packed head word, lane i at [8i+7:8i]
//   ovf_sticky     at least one word was dropped since the last clear
//   beat_count     number of words accepted by the consumer (wraps)
//   idle           no stage valid and FIFO empty
module psum_requant_writer #(
    parameter int LANES      = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          psum_wen,
    input  logic [ADDR_WIDTH-1:0]         psum_waddr,
    input  logic [LANES*ACC_WIDTH-1:0]    psum_wdata,
    input  logic [31:0]                   cfg_bias,
    input  logic [4:0]                    cfg_shift,
    input  logic                          clr_ovf,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    output logic [LANES*OUT_WIDTH-1:0]    out_data,
    output logic                          ovf_sticky,
    output logic [15:0]                   beat_count,
    output logic                          idle
);

    localparam int SUM_W   = ACC_WIDTH + 1;   // bias add cannot wrap
    localparam int RND_W   = ACC_WIDTH + 2;   // rounding add cannot wrap
    localparam int DATA_W  = LANES * OUT_WIDTH;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_W + ADDR_WIDTH;

    localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;   // -SAT_MAX - 1

    // Pipeline state
    logic                          s1_valid_reg, s2_valid_reg, s3_valid_reg;
    logic [ADDR_WIDTH-1:0]         s1_addr_reg, s2_addr_reg, s3_addr_reg;
    logic [LANES*SUM_W-1:0]        s1_sum_reg, s1_sum_next;
    logic [LANES*RND_W-1:0]        s2_shift_reg, s2_shift_next;
    logic [DATA_W-1:0]             s3_data_reg, s3_data_next;

    logic [SUM_W-1:0]              bias_ext;
    logic [RND_W-1:0]              rnd_const;

    assign bias_ext  = {{(SUM_W-32){cfg_bias[31]}}, cfg_bias};
    // Half an LSB of the shifted result; zero when cfg_shift is 0.
    assign rnd_const = (RND_W'(1) << cfg_shift) >> 1;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [ACC_WIDTH-1:0]     psum_lane;
        logic [SUM_W-1:0]         sum_lane;
        logic signed [RND_W-1:0]  rnd_lane;
        logic signed [RND_W-1:0]  shifted_lane;
        logic [OUT_WIDTH-1:0]     sat_lane;

        // S1 input: sign-extended psum + sign-extended bias
        assign psum_lane = psum_wdata[gi*ACC_WIDTH +: ACC_WIDTH];
        assign sum_lane  = {psum_lane[ACC_WIDTH-1], psum_lane} + bias_ext;
        assign s1_sum_next[gi*SUM_W +: SUM_W] = sum_lane;

        // S2 input: round half up, then arithmetic shift
        assign rnd_lane = {s1_sum_reg[gi*SUM_W + SUM_W - 1], s1_sum_reg[gi*SUM_W +: SUM_W]}
                          + rnd_const;
        assign s2_shift_next[gi*RND_W +: RND_W] = rnd_lane >>> cfg_shift;

        // S3 input: saturate (or ReLU-clamp) to the output width
        assign shifted_lane = s2_shift_reg[gi*RND_W +: RND_W];
        always_comb begin
            sat_lane = shifted_lane[OUT_WIDTH-1:0];
            if (shifted_lane > SAT_MAX) begin
                sat_lane = SAT_MAX[OUT_WIDTH-1:0];
`ifdef PSUM_REQUANT_RELU_EN
            end else if (shifted_lane[RND_W-1]) begin
                sat_lane = '0;
`else
            end else if (shifted_lane < SAT_MIN) begin
                sat_lane = SAT_MIN[OUT_WIDTH-1:0];
`endif
            end
        end
        assign s3_data_next[gi*OUT_WIDTH +: OUT_WIDTH] = sat_lane;
    end

    // Control path of the pipeline: the reset clears in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s3_valid_reg <= 1'b0;
            s1_addr_reg  <= '0;
            s2_addr_reg  <= '0;
            s3_addr_reg  <= '0;
        end else begin
            s1_valid_reg <= psum_wen;
            s2_valid_reg <= s1_valid_reg;
            s3_valid_reg <= s2_valid_reg;
            s1_addr_reg  <= psum_waddr;
            s2_addr_reg  <= s1_addr_reg;
            s3_addr_reg  <= s2_addr_reg;
        end
    end

    // Datapath registers need no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        s1_sum_reg   <= s1_sum_next;
        s2_shift_reg <= s2_shift_next;
        s3_data_reg  <= s3_data_next;
    end

    // Output FIFO. The head is read combinationally so that it is presented
    // in the same cycle the count becomes non-zero. This keeps the 3-edge
    // latency.
    logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]  head_entry;
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                fifo_full, pop, push, drop;

    assign fifo_full = (count_reg == CNT_W'(FIFO_DEPTH));
    assign pop       = out_valid && out_ready;
    // When the FIFO is full, a same-cycle pop frees the slot the push needs.
    assign push      = s3_valid_reg && (!fifo_full || pop);
    assign drop      = s3_valid_reg && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {s3_addr_reg, s3_data_reg};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_sticky <= 1'b0;
            beat_count <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg  <= count_reg + CNT_W'(push) - CNT_W'(pop);
            ovf_sticky <= (ovf_sticky && !clr_ovf) || drop;
            if (pop) beat_count <= beat_count + 16'd1;
        end
    end

    assign head_entry = fifo_mem[rd_ptr_reg];
    assign out_valid  = (count_reg != '0);
    // Zero when empty, so outputs read 0 in reset rather than stale memory.
    assign out_data   = out_valid ? head_entry[DATA_W-1:0] : '0;
    assign out_addr   = out_valid ? head_entry[ENTRY_W-1 -: ADDR_WIDTH] : '0;
    assign idle       = !s1_valid_reg && !s2_valid_reg && !s3_valid_reg && !out_valid;

endmodule

// File: doc/psum_requant_writer.md
Name: psum_requant_writer

Overview:
- Sits directly downstream of the PE system top and consumes its final-result write stream: 10-bit address, 512-bit data (16 lanes × 32-bit signed), write enable.
- Per lane, adds a global bias, applies a rounding arithmetic right shift, then saturates to int8.
- Packs the 16 int8 results into one 128-bit word, queues it with its address, and emits it over a valid/ready interface to the output activation buffer writer.
- The upstream stream has no backpressure. Drops on overflow are flagged, never silent.

Parameters:
- LANES, 16, number of 32-bit accumulator lanes per beat
- ACC_WIDTH, 32, signed accumulator width per lane
- OUT_WIDTH, 8, signed output width per lane
- ADDR_WIDTH, 10, result address width
- FIFO_DEPTH, 8, output queue entries; power of 2, at least 4

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- psum_wen  in  1  result beat valid; every asserted cycle is one beat
- psum_waddr  in  ADDR_WIDTH  result address
- psum_wdata  in  LANES*ACC_WIDTH  lane i = bits [32i+31:32i], signed
- cfg_bias  in  32  signed bias added to every lane
- cfg_shift  in  5  right-shift amount, 0..31
- clr_ovf  in  1  pulse; clears ovf_sticky
- out_valid  out  1  output word available
- out_ready  in  1  consumer accepts word when out_valid and out_ready are both high
- out_addr  out  ADDR_WIDTH  address carried unchanged from input
- out_data  out  LANES*OUT_WIDTH  lane i = bits [8i+7:8i]
- ovf_sticky  out  1  at least one beat dropped since last clear
- beat_count  out  16  words accepted by consumer; wraps at 65535 → 0
- idle  out  1  pipeline and FIFO both empty

Behaviour:
- Reset (asynchronous, rst_n low): all pipeline valids 0; FIFO pointers and count 0; out_valid 0; out_addr 0; out_data 0; ovf_sticky 0; beat_count 0; idle 1. Reset asserted mid-operation discards all in-flight beats and all queued words.
- Pipeline: 3 registered stages, each carrying a valid bit and the address. It always advances; there is no stall path to upstream.
  - S1: sum = sign-extended psum + sign-extended cfg_bias, 33-bit; no wrap.
  - S2: rnd = sum + (cfg_shift==0 ? 0 : 1<<(cfg_shift-1)), 34-bit; shifted = rnd >>> cfg_shift (arithmetic). Result is round-half-up toward +inf.
  - S3: saturate shifted to [-128, 127]; pack lanes.
- cfg_bias and cfg_shift are sampled at the stage that uses them. Software holds them stable while the engine runs.
- FIFO push: S3 valid, at the rising edge.
  - If count==FIFO_DEPTH and no pop occurs the same cycle, the word is dropped and ovf_sticky sets.
  - If count==FIFO_DEPTH and a pop occurs the same cycle, push and pop both happen and count is unchanged.
- FIFO pop: out_valid && out_ready. beat_count increments on each pop.
- out_valid = count != 0. out_addr and out_data show the head entry and hold stable while out_valid is high and out_ready is low.
- Latency: psum_wen sampled at edge E0 → out_valid high after edge E3, provided the FIFO is empty and not full. Back-to-back input gives one output per cycle when out_ready is held high.
- clr_ovf and a new overflow in the same cycle: ovf_sticky ends at 1 (set wins).
- idle = no stage valid and count == 0.
- No internal state machine beyond the pipeline valids and FIFO count. Words leave in input order; addresses are never reordered or merged.

Optional Feature:
- Macro: PSUM_REQUANT_RELU_EN.
- Defined: S3 clamps to [0, 127]; any negative shifted value gives 0. This is the fused ReLU.
- Undefined: signed saturation to [-128, 127] as in the baseline.
- Port list and latency are identical in both builds.

Test Plan:
- Single beat, out_ready=1: addr=0x005, all lanes=1000, bias=24, shift=3 → (1024+4)>>>3=128 → saturates; out_data lanes all 0x7F; out_addr=0x005; out_valid high 4 cycles after psum_wen.
- Rounding and sign cases, bias=0, shift=2:
  - lane values 5, 6, -5, -6, -1000 → 1, 2, -1, -1, -128 (0x01, 0x02, 0xFF, 0xFF, 0x80).
  - With PSUM_REQUANT_RELU_EN: 0x01, 0x02, 0x00, 0x00, 0x00.
- Shift 0 edge, bias=-1: lanes 0, 128, -128 → -1, 127, -128; check lane bit order with a distinct value per lane.
- Backpressure: out_ready=0, 12 consecutive beats with addr 0..11:
  - 8 words queued; beats 8..11 dropped; ovf_sticky=1.
  - Release out_ready: addresses 0..7 emerge in order; beat_count=8; idle=1 afterwards.
  - clr_ovf pulse → ovf_sticky=0.
- Full with simultaneous pop: FIFO at 8, out_ready=1 while a new beat arrives → no drop, count stays 8, ovf_sticky stays 0.
- Async reset mid-stream: assert rst_n low between edges with 3 beats in flight and 5 queued → immediately out_valid=0, idle=1, beat_count=0; after release, no stale words emerge.
